// File: rtl/irq_ack_dispatcher.sv
// ---------------------------------------------------------------------------
// irq_ack_dispatcher
//
// Purpose:
//   Sits behind the combinational 27-channel, three-bus priority interrupt
//   controller. It samples the bus-grant flags and the encoded channel code,
//   and turns them back into a one-hot acknowledge on the winning bus. It
//   holds that acknowledge until the requester drops its line or a timeout
//   expires. It also counts completed services and pulses err on protocol
//   errors (illegal channel code or timeout).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   grant_valid  controller outputs are valid this cycle
//   pa/pb/pc     bus-grant flags (priority A > B > C)
//   chan         encoded channel index, legal 0..NCH-1
//   req_a/b/c    live request lines per bus
//   ack_a/b/c    registered one-hot acknowledge
//   busy         high whenever the FSM is not IDLE
//   err          registered one-cycle error pulse
//   served_cnt   completed-service counter, wraps modulo 256
// ---------------------------------------------------------------------------
module irq_ack_dispatcher #(
  parameter int NCH     = 9,
  parameter int CW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            grant_valid,
  input  logic            pa,
  input  logic            pb,
  input  logic            pc,
  input  logic [CW-1:0]   chan,
  input  logic [NCH-1:0]  req_a,
  input  logic [NCH-1:0]  req_b,
  input  logic [NCH-1:0]  req_c,
  output logic [NCH-1:0]  ack_a,
  output logic [NCH-1:0]  ack_b,
  output logic [NCH-1:0]  ack_c,
  output logic            busy,
  output logic            err,
  output logic [7:0]      served_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t          state_reg;
  logic [2:0]      bus_reg;        // one-hot captured bus: [0]=A, [1]=B, [2]=C
  logic [NCH-1:0]  sel_reg;        // one-hot captured channel
  logic [7:0]      timer_reg;
  logic [NCH-1:0]  ack_a_reg;
  logic [NCH-1:0]  ack_b_reg;
  logic [NCH-1:0]  ack_c_reg;
  logic            busy_reg;
  logic            err_reg;
  logic [7:0]      served_cnt_reg;

  // Channel code decoded to one-hot. Codes >= NCH decode to all zeros,
  // so "any bit set" doubles as the legal-code check.
  logic [NCH-1:0]  chan_dec;
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan_dec
    assign chan_dec[gi] = (chan == CW'(gi));
  end

  logic chan_ok;
  logic any_flag;
  logic [2:0] bus_pick;

  assign chan_ok  = |chan_dec;
  assign any_flag = pa | pb | pc;
  // Fixed priority A > B > C.
  assign bus_pick = {~pa & ~pb & pc, ~pa & pb, pa};

  // Live request of the captured requester. Bus and channel are both one-hot,
  // so an AND-OR mux selects the single line.
  logic [NCH-1:0] req_sel;
  logic           req_hit;

  assign req_sel = ({NCH{bus_reg[0]}} & req_a)
                 | ({NCH{bus_reg[1]}} & req_b)
                 | ({NCH{bus_reg[2]}} & req_c);
  assign req_hit = |(req_sel & sel_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bus_reg        <= '0;
      sel_reg        <= '0;
      timer_reg      <= '0;
      ack_a_reg      <= '0;
      ack_b_reg      <= '0;
      ack_c_reg      <= '0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
      served_cnt_reg <= '0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid && any_flag) begin
            busy_reg <= 1'b1;
            if (chan_ok) begin
              state_reg <= ACK;
              bus_reg   <= bus_pick;
              sel_reg   <= chan_dec;
              timer_reg <= '0;
              ack_a_reg <= bus_pick[0] ? chan_dec : '0;
              ack_b_reg <= bus_pick[1] ? chan_dec : '0;
              ack_c_reg <= bus_pick[2] ? chan_dec : '0;
            end else begin
              state_reg <= ERR;
              err_reg   <= 1'b1;
            end
          end
        end

        ACK: begin
          // Release is checked first, so it wins over a coincident timeout.
          if (!req_hit) begin
            state_reg      <= DONE;
            ack_a_reg      <= '0;
            ack_b_reg      <= '0;
            ack_c_reg      <= '0;
            served_cnt_reg <= served_cnt_reg + 8'd1;
          end else if (timer_reg == TIMER_LAST) begin
            state_reg <= ERR;
            ack_a_reg <= '0;
            ack_b_reg <= '0;
            ack_c_reg <= '0;
            err_reg   <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 8'd1;
          end
        end

        // DONE swallows one cycle so a grant left over from the serviced
        // request cannot be re-captured immediately.
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        ERR: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          ack_a_reg <= '0;
          ack_b_reg <= '0;
          ack_c_reg <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_a      = ack_a_reg;
  assign ack_b      = ack_b_reg;
  assign ack_c      = ack_c_reg;
  assign busy       = busy_reg;
  assign err        = err_reg;
  assign served_cnt = served_cnt_reg;

endmodule
